// File: rtl/lru_pkg.sv
// Shared types and one-hot helpers for the per-set LRU access controller.
package lru_pkg;

    localparam int DEPTH_DEF = 8;
    localparam int TAG_W_DEF = 20;
    localparam int VEC_MAX   = 64;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        FILL_REQ,
        FILL_WAIT,
        RESP
    } lru_state_e;

    typedef logic [VEC_MAX-1:0] vec_t;

    // Callers zero-extend their DEPTH-wide vectors into vec_t.
    function automatic logic onehot_chk(input vec_t v);
        return (v != '0) && ((v & (v - vec_t'(1))) == '0);
    endfunction

    function automatic vec_t prio_lowest(input vec_t v);
        return v & (~v + vec_t'(1));
    endfunction

endpackage

// File: rtl/lru_tag_cam.sv
// Fully associative tag/valid store with a one-hot write port and a combinational match vector.
module lru_tag_cam
    import lru_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int TAG_W = TAG_W_DEF
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             wr_en,
    input  logic [DEPTH-1:0] wr_way,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic [TAG_W-1:0] lookup_tag,
    output logic [DEPTH-1:0] valid,
    output logic [DEPTH-1:0] match,
    output logic             multi_match
);

    logic [TAG_W-1:0] tags [DEPTH];

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            valid <= '0;
        end else if (wr_en) begin
            valid <= valid | wr_way;
        end
    end

    // NOTE: the tag array has no reset; a way's contents only matter once its valid bit is set.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_en && wr_way[i]) begin
                tags[i] <= wr_tag;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            match[i] = valid[i] && (tags[i] == lookup_tag);
        end
    end

    assign multi_match = (match != '0) && !onehot_chk(vec_t'(match));

endmodule

// File: rtl/lru_access_ctrl.sv
// Per-set lookup/refill controller feeding move-to-front strobes into the LRU stack.
module lru_access_ctrl
    import lru_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int TAG_W = TAG_W_DEF
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [TAG_W-1:0] req_tag,
    output logic             resp_valid,
    output logic             resp_hit,
    output logic [DEPTH-1:0] resp_way,
    output logic             fill_req_valid,
    input  logic             fill_req_ready,
    output logic [TAG_W-1:0] fill_req_tag,
    input  logic             fill_done,
    output logic             update_lru_stack,
    output logic [DEPTH-1:0] accessed_blk,
    input  logic [DEPTH-1:0] victim_blk,
    output logic             lru_err
);

    lru_state_e       state;
    logic [TAG_W-1:0] tag_q;
    logic [DEPTH-1:0] fill_way;
    logic [DEPTH-1:0] valid;
    logic [DEPTH-1:0] match;
    logic             multi_match;
    logic [DEPTH-1:0] hit_way;
    logic [DEPTH-1:0] free_way;
    logic [DEPTH-1:0] miss_way;
    logic             miss_err;
    logic             wr_en;

    assign req_ready = (state == IDLE);
    assign wr_en     = (state == FILL_WAIT) && fill_done;

    lru_tag_cam #(
        .DEPTH (DEPTH),
        .TAG_W (TAG_W)
    ) u_cam (
        .clk         (clk),
        .rst_b       (rst_b),
        .wr_en       (wr_en),
        .wr_way      (fill_way),
        .wr_tag      (tag_q),
        .lookup_tag  (tag_q),
        .valid       (valid),
        .match       (match),
        .multi_match (multi_match)
    );

    // NOTE: every output of this block gets a default first so no path leaves a latch behind.
    always_comb begin
        hit_way  = DEPTH'(prio_lowest(vec_t'(match)));
        free_way = DEPTH'(prio_lowest(vec_t'(~valid)));
        miss_way = free_way;
        miss_err = 1'b0;
        if (free_way == '0) begin
            if (onehot_chk(vec_t'(victim_blk))) begin
                miss_way = victim_blk;
            end else begin
                miss_way = DEPTH'(1);
                miss_err = 1'b1;
            end
        end
    end

    // NOTE: state and registered outputs use non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state            <= IDLE;
            tag_q            <= '0;
            fill_way         <= '0;
            resp_valid       <= 1'b0;
            resp_hit         <= 1'b0;
            resp_way         <= '0;
            fill_req_valid   <= 1'b0;
            fill_req_tag     <= '0;
            update_lru_stack <= 1'b0;
            accessed_blk     <= '0;
            lru_err          <= 1'b0;
        end else begin
            resp_valid       <= 1'b0;
            update_lru_stack <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        tag_q <= req_tag;
                        state <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (match != '0) begin
                        resp_valid       <= 1'b1;
                        resp_hit         <= 1'b1;
                        resp_way         <= hit_way;
                        update_lru_stack <= 1'b1;
                        accessed_blk     <= hit_way;
                        state            <= RESP;
                        if (multi_match) lru_err <= 1'b1;
                    end else begin
                        fill_way       <= miss_way;
                        fill_req_valid <= 1'b1;
                        fill_req_tag   <= tag_q;
                        state          <= FILL_REQ;
                        if (miss_err) lru_err <= 1'b1;
                    end
                end
                FILL_REQ: begin
                    if (fill_req_ready) begin
                        fill_req_valid <= 1'b0;
                        state          <= FILL_WAIT;
                    end
                end
                FILL_WAIT: begin
                    if (fill_done) begin
                        resp_valid       <= 1'b1;
                        resp_hit         <= 1'b0;
                        resp_way         <= fill_way;
                        update_lru_stack <= 1'b1;
                        accessed_blk     <= fill_way;
                        state            <= RESP;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lru_access_ctrl.sv
// Scoreboard bench: driver pushes model predictions, a monitor pops them on every response pulse.
module tb_lru_access_ctrl;

    localparam int DEPTH = 8;
    localparam int TAG_W = 20;

    logic             clk = 1'b0;
    logic             rst_b = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [TAG_W-1:0] req_tag = '0;
    logic             resp_valid;
    logic             resp_hit;
    logic [DEPTH-1:0] resp_way;
    logic             fill_req_valid;
    logic             fill_req_ready = 1'b0;
    logic [TAG_W-1:0] fill_req_tag;
    logic             fill_done = 1'b0;
    logic             update_lru_stack;
    logic [DEPTH-1:0] accessed_blk;
    logic [DEPTH-1:0] victim_blk = '0;
    logic             lru_err;

    lru_access_ctrl #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk              (clk),
        .rst_b            (rst_b),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_tag          (req_tag),
        .resp_valid       (resp_valid),
        .resp_hit         (resp_hit),
        .resp_way         (resp_way),
        .fill_req_valid   (fill_req_valid),
        .fill_req_ready   (fill_req_ready),
        .fill_req_tag     (fill_req_tag),
        .fill_done        (fill_done),
        .update_lru_stack (update_lru_stack),
        .accessed_blk     (accessed_blk),
        .victim_blk       (victim_blk),
        .lru_err          (lru_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int exp_resp_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic             hit;
        logic [DEPTH-1:0] way;
    } exp_t;

    exp_t sb_q[$];

    // Reference: a plain array of ways, searched by index.
    logic [TAG_W-1:0] m_tag [DEPTH];
    bit               m_valid [DEPTH];
    bit               m_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic abort(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timeout waiting on DUT", name);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    endtask

    function automatic void model_clear();
        for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
        m_err = 1'b0;
    endfunction

    function automatic exp_t model_access(input logic [TAG_W-1:0] tag, input logic [DEPTH-1:0] victim);
        exp_t e;
        int   w = -1;
        for (int i = 0; i < DEPTH; i++) begin
            if (w < 0 && m_valid[i] && m_tag[i] == tag) w = i;
        end
        e.hit = (w >= 0);
        if (w < 0) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w < 0 && !m_valid[i]) w = i;
            end
            if (w < 0) begin
                if ($countones(victim) == 1) begin
                    for (int i = 0; i < DEPTH; i++) if (victim[i]) w = i;
                end else begin
                    w = 0;
                    m_err = 1'b1;
                end
            end
            m_valid[w] = 1'b1;
            m_tag[w]   = tag;
        end
        e.way = DEPTH'(1) << w;
        return e;
    endfunction

    // Monitor: every response pulse must match the oldest outstanding prediction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (resp_valid || update_lru_stack) begin
                check("update_with_resp", 32'(update_lru_stack), 32'(resp_valid));
                if (resp_valid) begin
                    if (sb_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_resp: got resp_valid=1 way=%0h required no response", resp_way);
                    end else begin
                        e = sb_q.pop_front();
                        check("resp_hit", 32'(resp_hit), 32'(e.hit));
                        check("resp_way", 32'(resp_way), 32'(e.way));
                        check("accessed_blk", 32'(accessed_blk), 32'(e.way));
                        check("resp_cycle", 32'(cyc), 32'(exp_resp_cyc));
                    end
                end
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) abort("wait_idle");
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_b = 1'b0;
        model_clear();
        @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);
    endtask

    task automatic do_req(input logic [TAG_W-1:0] tag, input logic [DEPTH-1:0] victim,
                          input int stall, input int done_dly, input bit stray);
        exp_t e;
        int   n;
        wait_idle();
        e = model_access(tag, victim);
        sb_q.push_back(e);
        req_valid  = 1'b1;
        req_tag    = tag;
        victim_blk = victim;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_tag   = TAG_W'($urandom);
        if (e.hit) begin
            exp_resp_cyc = cyc + 1;
            @(negedge clk);
            check("hit_no_fill", 32'(fill_req_valid), 32'(0));
        end else begin
            @(negedge clk);
            @(negedge clk);
            check("fill_req_valid", 32'(fill_req_valid), 32'(1));
            check("fill_req_tag", 32'(fill_req_tag), 32'(tag));
            check("req_ready_busy", 32'(req_ready), 32'(0));
            for (int i = 0; i < stall; i++) begin
                if (stray) begin
                    req_valid = 1'b1;
                    req_tag   = tag ^ TAG_W'(1);
                end
                @(negedge clk);
                check("fill_hold_valid", 32'(fill_req_valid), 32'(1));
                check("fill_hold_tag", 32'(fill_req_tag), 32'(tag));
                check("stall_req_ready", 32'(req_ready), 32'(0));
            end
            req_valid      = 1'b0;
            fill_req_ready = 1'b1;
            @(posedge clk);
            #1;
            fill_req_ready = 1'b0;
            repeat (done_dly) @(negedge clk);
            check("fill_req_dropped", 32'(fill_req_valid), 32'(0));
            fill_done    = 1'b1;
            exp_resp_cyc = cyc + 1;
            @(posedge clk);
            #1;
            fill_done = 1'b0;
        end
        n = 0;
        while (sb_q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() != 0) abort("resp_wait");
        @(negedge clk);
        check("req_ready_after", 32'(req_ready), 32'(1));
        check("lru_err", 32'(lru_err), 32'(m_err));
    endtask

    initial begin
        #400000;
        abort("watchdog");
    end

    initial begin
        logic [DEPTH-1:0] v;
        int               r;
        model_clear();

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'(1));
        check("rst_resp_valid", 32'(resp_valid), 32'(0));
        check("rst_fill_req_valid", 32'(fill_req_valid), 32'(0));
        check("rst_update", 32'(update_lru_stack), 32'(0));
        check("rst_lru_err", 32'(lru_err), 32'(0));
        check("rst_resp_way", 32'(resp_way), 32'(0));
        rst_b = 1'b1;
        @(negedge clk);
        check("post_rst_req_ready", 32'(req_ready), 32'(1));

        // Cold miss, then hit on the same tag
        do_req(20'h00ABC, 8'h00, 0, 3, 1'b0);
        do_req(20'h00ABC, 8'h00, 0, 3, 1'b0);

        // Fill every way, then replace the stack's victim
        do_reset();
        for (int i = 0; i < DEPTH; i++) do_req(TAG_W'(32'h10 + i), 8'h00, 0, 1, 1'b0);
        do_req(20'h00018, 8'h04, 0, 2, 1'b0);
        do_req(20'h00012, 8'h08, 0, 2, 1'b0);
        do_req(20'h00018, 8'h01, 0, 1, 1'b0);

        // Back-pressured fill request with a stray request held against it
        do_req(20'h00055, 8'h20, 5, 2, 1'b1);

        // Broken victim vector while full; error stays sticky
        do_req(20'h00066, 8'h00, 0, 1, 1'b0);
        do_req(20'h00067, 8'h10, 1, 1, 1'b0);

        // Reset while waiting on the fill; the late fill_done must be ignored
        wait_idle();
        req_valid  = 1'b1;
        req_tag    = 20'h00077;
        victim_blk = 8'h02;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        fill_req_ready = 1'b1;
        @(posedge clk);
        #1;
        fill_req_ready = 1'b0;
        @(negedge clk);
        rst_b = 1'b0;
        model_clear();
        @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);
        check("mid_rst_req_ready", 32'(req_ready), 32'(1));
        check("mid_rst_lru_err", 32'(lru_err), 32'(0));
        fill_done = 1'b1;
        @(posedge clk);
        #1;
        fill_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("no_resp_after_rst", 32'(resp_valid), 32'(0));
            check("no_fill_after_rst", 32'(fill_req_valid), 32'(0));
        end
        do_req(20'h00077, 8'h02, 0, 1, 1'b0);

        // Randomized traffic over a small tag pool so hits, misses and evictions all recur
        do_reset();
        for (int k = 0; k < 80; k++) begin
            r = $urandom_range(0, 9);
            if (r == 0)      v = 8'h00;
            else if (r == 1) v = 8'h03;
            else             v = DEPTH'(1) << $urandom_range(0, DEPTH - 1);
            do_req(TAG_W'(32'h200 + $urandom_range(0, 11)), v,
                   $urandom_range(0, 3), $urandom_range(1, 4), 1'($urandom_range(0, 1)));
        end

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(sb_q.size()), 32'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
